// File: rtl/core_inst_sequencer_if.sv
// rtl/core_inst_sequencer_if.sv - host/core-facing signal bundle of the instruction sequencer
interface core_inst_sequencer_if #(
   parameter int len_w = 4
);
   logic             start;
   logic             abort;
   logic [len_w-1:0] num_rows;
   logic             ofifo_valid;
   logic [18:0]      inst;
   logic             mem_req;
   logic             busy;
   logic             done;
   logic [3:0]       phase;

   modport master (
      output start, abort, num_rows, ofifo_valid,
      input  inst, mem_req, busy, done, phase
   );

   modport slave (
      input  start, abort, num_rows, ofifo_valid,
      output inst, mem_req, busy, done, phase
   );
endinterface

// File: rtl/core_inst_sequencer.sv
// rtl/core_inst_sequencer.sv - walks the core through one attention tile: Q/K write, K load, execute, drain, writeback, SFP
module core_inst_sequencer #(
   parameter int col   = 8,
   parameter int pr    = 16,
   parameter int len_w = 4,
   parameter int drain = 16
) (
   input logic                 clk,
   input logic                 reset,
   core_inst_sequencer_if.slave bus
);
   localparam int top_a   = (drain > col) ? drain : col;
   localparam int top_b   = (pr > (1 << len_w)) ? pr : (1 << len_w);
   localparam int cnt_top = (top_a > top_b) ? top_a : top_b;
   localparam int cnt_w   = (cnt_top > 2) ? $clog2(cnt_top) : 1;

   localparam logic [cnt_w-1:0] col_last   = cnt_w'(col - 1);
   localparam logic [cnt_w-1:0] drain_last = cnt_w'(drain - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_QWR   = 4'd1,
      S_KWR   = 4'd2,
      S_KLD   = 4'd3,
      S_KGAP  = 4'd4,
      S_EXEC  = 4'd5,
      S_DRAIN = 4'd6,
      S_OWR   = 4'd7,
      S_SFPA  = 4'd8,
      S_SFPD  = 4'd9,
      S_DONE  = 4'd10
   } state_t;

   state_t           state_q, state_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic [len_w-1:0] rows_q, rows_d;
   logic [18:0]      inst_q, inst_d;
   logic             mem_req_q, mem_req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [cnt_w-1:0] row_last;
   logic [3:0]       addr;

   assign row_last = cnt_w'(rows_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rows_d  = rows_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               state_d = S_QWR;
               rows_d  = bus.num_rows;
            end
         end
         S_QWR:   if (cnt_q == row_last)   begin state_d = S_KWR;   cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         S_KWR:   if (cnt_q == col_last)   begin state_d = S_KLD;   cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         S_KLD:   if (cnt_q == col_last)   begin state_d = S_KGAP;  cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         S_KGAP:  begin state_d = S_EXEC; cnt_d = '0; end
         S_EXEC:  if (cnt_q == row_last)   begin state_d = S_DRAIN; cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         S_DRAIN: if (cnt_q == drain_last) begin state_d = S_OWR;   cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         // A row only counts as written back in a cycle that actually carries ofifo_rd.
         S_OWR: begin
            if (inst_q[16]) begin
               if (cnt_q == row_last) begin state_d = S_SFPA; cnt_d = '0; end
               else cnt_d = cnt_q + cnt_w'(1);
            end
         end
         S_SFPA:  if (cnt_q == row_last)   begin state_d = S_SFPD;  cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         S_SFPD:  if (cnt_q == row_last)   begin state_d = S_DONE;  cnt_d = '0; end else cnt_d = cnt_q + cnt_w'(1);
         S_DONE:  begin state_d = S_IDLE; cnt_d = '0; end
         default: begin state_d = S_IDLE; cnt_d = '0; end
      endcase
      if (bus.abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   // Outputs are decoded from the next state so each pattern lines up with its state cycle;
   // the OWR read decision therefore uses ofifo_valid one cycle ahead of the read.
   always_comb begin
      inst_d = '0;
      addr   = 4'(cnt_d);
      case (state_d)
         S_QWR:   begin inst_d[4] = 1'b1; inst_d[15:12] = addr; end
         S_KWR:   begin inst_d[2] = 1'b1; inst_d[15:12] = addr; end
         S_KLD:   begin inst_d[3] = 1'b1; inst_d[6] = 1'b1; inst_d[15:12] = addr; end
         S_EXEC:  begin inst_d[5] = 1'b1; inst_d[7] = 1'b1; inst_d[15:12] = addr; end
         S_OWR: begin
            if (bus.ofifo_valid) begin
               inst_d[16] = 1'b1; inst_d[0] = 1'b1; inst_d[11:8] = addr;
            end
         end
         S_SFPA:  begin inst_d[1] = 1'b1; inst_d[17] = 1'b1; inst_d[11:8] = addr; end
         S_SFPD:  begin inst_d[1] = 1'b1; inst_d[18] = 1'b1; inst_d[11:8] = addr; end
         default: inst_d = '0;
      endcase
      mem_req_d = (state_d == S_QWR) || (state_d == S_KWR);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rows_q    <= '0;
         inst_q    <= '0;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rows_q    <= rows_d;
         inst_q    <= inst_d;
         mem_req_q <= mem_req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.inst    = inst_q;
   assign bus.mem_req = mem_req_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.phase   = state_q;
endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb/tb_core_inst_sequencer.sv - directed bench for core_inst_sequencer with a per-cycle schedule table
module tb_core_inst_sequencer;
   logic clk = 1'b0;
   logic reset;

   core_inst_sequencer_if #(.len_w(4)) bus ();

   core_inst_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [18:0] tr_inst  [0:127];
   logic [3:0]  tr_phase [0:127];
   logic [2:0]  tr_ctl   [0:127];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected {mem_req,busy,done,phase,inst} at cycle c after start, col=8, drain=16,
   // r rows, sn stall cycles beginning at OWR row 2.
   function automatic logic [25:0] exp_at(input int c, input int r, input int sn);
      int q0, k0, l0, g0, e0, d0, o0, a0, v0, dn, s0, row;
      logic [18:0] i;
      logic [3:0]  p;
      logic        mr, bz, dz;
      q0 = 1; k0 = q0 + r; l0 = k0 + 8; g0 = l0 + 8; e0 = g0 + 1; d0 = e0 + r;
      o0 = d0 + 16; a0 = o0 + r + sn; v0 = a0 + r; dn = v0 + r; s0 = o0 + 2;
      i = '0;
      p = 4'd0;
      if (c >= q0 && c < k0)      begin p = 4'd1; i = 19'h00010 | 19'((c - q0) << 12); end
      else if (c >= k0 && c < l0) begin p = 4'd2; i = 19'h00004 | 19'((c - k0) << 12); end
      else if (c >= l0 && c < g0) begin p = 4'd3; i = 19'h00048 | 19'((c - l0) << 12); end
      else if (c == g0)           begin p = 4'd4; end
      else if (c >= e0 && c < d0) begin p = 4'd5; i = 19'h000A0 | 19'((c - e0) << 12); end
      else if (c >= d0 && c < o0) begin p = 4'd6; end
      else if (c >= o0 && c < a0) begin
         p = 4'd7;
         if (!(sn > 0 && c >= s0 && c < s0 + sn)) begin
            row = c - o0 - ((sn > 0 && c >= s0 + sn) ? sn : 0);
            i = 19'h10001 | 19'(row << 8);
         end
      end
      else if (c >= a0 && c < v0) begin p = 4'd8; i = 19'h20002 | 19'((c - a0) << 8); end
      else if (c >= v0 && c < dn) begin p = 4'd9; i = 19'h40002 | 19'((c - v0) << 8); end
      else if (c == dn)           begin p = 4'd10; end
      mr = (c >= q0 && c < l0);
      bz = (c >= 1 && c <= dn);
      dz = (c == dn);
      return {mr, bz, dz, p, i};
   endfunction

   // Cycle 0 is the start cycle; outputs are sampled 1 time unit after each rising edge.
   task automatic run(input int nr, input int sn, input int rep_c, input int abort_c, input int ncyc);
      int r, s0;
      r  = nr + 1;
      s0 = 1 + r + 8 + 8 + 1 + r + 16 + 2;
      for (int c = 0; c < ncyc; c++) begin
         tr_inst[c]  = bus.inst;
         tr_phase[c] = bus.phase;
         tr_ctl[c]   = {bus.mem_req, bus.busy, bus.done};
         bus.start       = (c == 0) || (c == rep_c);
         bus.num_rows    = (c == 0) ? 4'(nr) : 4'(~nr);
         bus.abort       = (c == abort_c);
         bus.ofifo_valid = !(sn > 0 && c >= s0 - 1 && c < s0 - 1 + sn);
         @(posedge clk);
         #1;
      end
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.ofifo_valid = 1'b1;
   endtask

   task automatic cmp_run(input string name, input int r, input int sn, input int ncyc, input int cut);
      logic [25:0] e;
      for (int c = 0; c < ncyc; c++) begin
         e = (c >= cut) ? 26'd0 : exp_at(c, r, sn);
         chk($sformatf("%s inst c%0d", name, c), 32'(tr_inst[c]), 32'(e[18:0]));
         chk($sformatf("%s phase c%0d", name, c), 32'(tr_phase[c]), 32'(e[22:19]));
         chk($sformatf("%s req/busy/done c%0d", name, c), 32'(tr_ctl[c]), 32'(e[25:23]));
      end
   endtask

   initial begin
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.num_rows    = 4'd0;
      bus.ofifo_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset inst", 32'(bus.inst), 32'd0);
      chk("reset ctl", 32'({bus.mem_req, bus.busy, bus.done, bus.phase}), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("idle inst %0d", i), 32'(bus.inst), 32'd0);
         chk($sformatf("idle ctl %0d", i), 32'({bus.mem_req, bus.busy, bus.done, bus.phase}), 32'd0);
      end

      run(7, 0, -1, -1, 80);
      cmp_run("base", 8, 0, 80, 999);

      run(7, 3, -1, -1, 82);
      cmp_run("stall", 8, 3, 82, 999);

      run(7, 0, -1, 29, 40);
      cmp_run("abort", 8, 0, 40, 30);

      run(0, 0, -1, -1, 45);
      cmp_run("r1", 1, 0, 45, 999);

      run(7, 0, 20, -1, 80);
      cmp_run("repulse", 8, 0, 80, 999);

      run(15, 0, -1, -1, 120);
      cmp_run("r16", 16, 0, 120, 999);

      bus.start    = 1'b1;
      bus.abort    = 1'b1;
      bus.num_rows = 4'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("abort beats start", 32'({bus.busy, bus.phase, bus.inst}), 32'd0);
      @(posedge clk);
      #1;
      chk("abort beats start next", 32'({bus.busy, bus.phase}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
